// File: rtl/snake_move_scheduler_if.sv
// Key/step bus between the direction decoder, the move scheduler and the game engine.
// The master side drives keypresses. The slave side (the scheduler) drives step, direction and status.
interface snake_move_scheduler_if #(
  parameter int QDEPTH = 4
);
  localparam int QW = $clog2(QDEPTH) + 1;

  logic          key_valid;
  logic [2:0]    key_dir;
  logic          step;
  logic [2:0]    step_dir;
  logic [2:0]    cur_dir;
  logic          running;
  logic          restart;
  logic [QW-1:0] q_count;
  logic          q_overflow;

  modport master (
    output key_valid, key_dir,
    input  step, step_dir, cur_dir, running, restart, q_count, q_overflow
  );

  modport slave (
    input  key_valid, key_dir,
    output step, step_dir, cur_dir, running, restart, q_count, q_overflow
  );
endinterface

// File: rtl/snake_move_scheduler.sv
// Snake move scheduler: queues direction keys and rejects reversals and repeats.
// It emits one step per game tick and commits one queued direction per step.
// A restart key flushes all state, and the block then waits in IDLE for the next direction key.
// Optional macro SPEEDUP_EN shortens the step period by TICK_DIV>>4 after every 16 steps.
// The period never drops below TICK_DIV>>2.
module snake_move_scheduler #(
  parameter int TICK_DIV = 5000000,
  parameter int QDEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  snake_move_scheduler_if.slave  bus
);
  localparam int CW = $clog2(TICK_DIV + 1);
  localparam int PW = $clog2(QDEPTH);
  localparam int QW = $clog2(QDEPTH) + 1;
  localparam logic [2:0] DIR_NONE = 3'b100;

  typedef enum logic [1:0] {IDLE, RUN, RSTRT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    mem [QDEPTH];
  logic [PW-1:0] head, tail, tail_m1;
  logic [QW-1:0] count;
  logic [2:0]    cur_dir, step_dir;
  logic          step, restart, ovf;

  logic          rst_key, dir_key, tick, empty, full, ok, push, pop, drop;
  logic [2:0]    eff;
  logic [CW-1:0] last;

`ifdef SPEEDUP_EN
  localparam logic [CW-1:0] PER0  = CW'(TICK_DIV);
  localparam logic [CW-1:0] DEC   = CW'(TICK_DIV >> 4);
  localparam logic [CW-1:0] FLOOR = CW'(TICK_DIV >> 2);
  logic [CW-1:0] period;
  logic [3:0]    nsteps;

  // Period shrinks every 16 steps. The new value applies from the counter wrap just taken.
  always_ff @(posedge clk) begin
    if (rst || rst_key) begin
      period <= PER0;
      nsteps <= '0;
    end else if (tick) begin
      nsteps <= nsteps + 4'd1;
      if (nsteps == 4'd15)
        period <= (period >= FLOOR + DEC) ? period - DEC : FLOOR;
    end
  end
  assign last = period - CW'(1);
`else
  assign last = CW'(TICK_DIV - 1);
`endif

  assign rst_key = bus.key_valid && (bus.key_dir == 3'b100);
  assign dir_key = bus.key_valid && !bus.key_dir[2];
  // A restart key takes priority, so it suppresses the tick in the same cycle.
  assign tick    = (state == RUN) && (cnt == last) && !rst_key;
  assign empty   = (count == '0);
  assign full    = (count == QW'(QDEPTH));
  assign tail_m1 = tail - PW'(1);
  // The effective tail is read before any pop in the same cycle.
  assign eff     = empty ? cur_dir : mem[tail_m1];
  assign ok      = dir_key && (bus.key_dir != eff) && ((bus.key_dir ^ eff) != 3'b010);
  assign pop     = tick && !empty;
  assign push    = (state == RUN) && ok && (!full || pop);
  assign drop    = (state == RUN) && ok && full && !pop;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (rst_key) state_nx = RSTRT;
    else begin
      case (state)
        IDLE:    if (dir_key) state_nx = RUN;
        RUN:     state_nx = RUN;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Queue storage; the tail slot is written on every accepted push
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= bus.key_dir;
  end

  // Tick counter, queue pointers, committed direction and the step and restart pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      cur_dir  <= DIR_NONE;
      step_dir <= DIR_NONE;
      step     <= 1'b0;
      restart  <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      step    <= 1'b0;
      restart <= 1'b0;
      if (rst_key) begin
        cnt      <= '0;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        ovf      <= 1'b0;
        cur_dir  <= DIR_NONE;
        step_dir <= DIR_NONE;
        restart  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (dir_key) cur_dir <= bus.key_dir;
          end
          RUN: begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
              step <= 1'b1;
              if (pop) begin
                cur_dir  <= mem[head];
                step_dir <= mem[head];
                head     <= head + PW'(1);
              end else begin
                step_dir <= cur_dir;
              end
            end
            if (push) tail <= tail + PW'(1);
            if (drop) ovf  <= 1'b1;
            count <= count + QW'(push) - QW'(pop);
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

  assign bus.step       = step;
  assign bus.step_dir   = step_dir;
  assign bus.cur_dir    = cur_dir;
  assign bus.running    = (state == RUN);
  assign bus.restart    = restart;
  assign bus.q_count    = count;
  assign bus.q_overflow = ovf;
endmodule

// File: tb/tb_snake_move_scheduler.sv
// Self-checking bench for snake_move_scheduler. It runs directed scenarios and then random traffic.
// The random traffic is compared against a queue-based reference model.
module tb_snake_move_scheduler;
  localparam int TD = 8;
  localparam int QD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_RST = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snake_move_scheduler_if #(.QDEPTH(QD)) bus();
  snake_move_scheduler #(.TICK_DIV(TD), .QDEPTH(QD)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errs = 0;
  int checks = 0;

  // Reference model, described in terms of the game rules
  int m_mode = M_IDLE;
  int m_phase = 0;
  int q[$];
  int m_cur = 4, m_sdir = 4;
  bit m_step = 0, m_restart = 0, m_ovf = 0;
  int m_period = TD;
  int m_nsteps = 0;

  always @(posedge clk) begin
    automatic int e, oldsz, kd;
    automatic bit tk, popped;
    kd = int'(bus.key_dir);
    if (rst) begin
      m_mode = M_IDLE; m_phase = 0; q.delete(); m_cur = 4; m_sdir = 4;
      m_step = 0; m_restart = 0; m_ovf = 0; m_period = TD; m_nsteps = 0;
    end else begin
      m_step = 0; m_restart = 0;
      if (bus.key_valid && kd == 4) begin
        q.delete(); m_ovf = 0; m_phase = 0; m_cur = 4; m_sdir = 4;
        m_mode = M_RST; m_restart = 1; m_period = TD; m_nsteps = 0;
      end else if (m_mode == M_IDLE) begin
        m_phase = 0;
        if (bus.key_valid && kd < 4) begin m_cur = kd; m_mode = M_RUN; end
      end else if (m_mode == M_RST) begin
        m_mode = M_IDLE;
      end else begin
        oldsz = q.size();
        e = (oldsz > 0) ? q[oldsz-1] : m_cur;
        tk = (m_phase == m_period - 1);
        popped = 0;
        if (tk) begin
          m_phase = 0;
          if (oldsz > 0) begin m_cur = q.pop_front(); popped = 1; end
          m_step = 1; m_sdir = m_cur;
`ifdef SPEEDUP_EN
          m_nsteps++;
          if (m_nsteps % 16 == 0)
            m_period = (m_period - TD/16 < TD/4) ? TD/4 : m_period - TD/16;
`endif
        end else m_phase++;
        if (bus.key_valid && kd < 4 && kd != e && (kd ^ e) != 2) begin
          if (oldsz == QD && !popped) m_ovf = 1;
          else q.push_back(kd);
        end
      end
    end
  end

  // Drive one key for exactly one cycle. The call starts and ends on a negedge.
  task automatic key(input logic [2:0] d);
    bus.key_valid = 1'b1; bus.key_dir = d;
    @(negedge clk);
    bus.key_valid = 1'b0; bus.key_dir = 3'b000;
  endtask

  // Advance to the negedge where step is high. The wait is bounded, and n returns the cycles taken.
  task automatic wait_step(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.step && n < 64);
  endtask

  task automatic test_reset();
    automatic bit bad = 0;
    rst = 1'b1; bus.key_valid = 1'b0; bus.key_dir = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.step !== 1'b0) begin errs++; $display("FAIL reset_step got=%b exp=0", bus.step); end
    checks++; if (bus.running !== 1'b0) begin errs++; $display("FAIL reset_running got=%b exp=0", bus.running); end
    checks++; if (bus.cur_dir !== 3'b100) begin errs++; $display("FAIL reset_cur_dir got=%0d exp=4", bus.cur_dir); end
    checks++; if (bus.step_dir !== 3'b100) begin errs++; $display("FAIL reset_step_dir got=%0d exp=4", bus.step_dir); end
    checks++; if (bus.q_count !== 3'd0) begin errs++; $display("FAIL reset_q_count got=%0d exp=0", bus.q_count); end
    checks++; if (bus.q_overflow !== 1'b0) begin errs++; $display("FAIL reset_q_overflow got=%b exp=0", bus.q_overflow); end
    checks++; if (bus.restart !== 1'b0) begin errs++; $display("FAIL reset_restart got=%b exp=0", bus.restart); end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.step !== 1'b0 || bus.running !== 1'b0 || bus.cur_dir !== 3'b100 || bus.q_count !== 3'd0) bad = 1;
    end
    checks++; if (bad) begin errs++; $display("FAIL idle_quiet got=activity exp=none"); end
    key(3'b110);
    checks++; if (bus.running !== 1'b0) begin errs++; $display("FAIL ignored_code_idle got=%b exp=0", bus.running); end
  endtask

  task automatic test_start();
    automatic int n;
    key(3'b011);
    checks++; if (bus.running !== 1'b1) begin errs++; $display("FAIL start_running got=%b exp=1", bus.running); end
    checks++; if (bus.cur_dir !== 3'd3) begin errs++; $display("FAIL start_cur_dir got=%0d exp=3", bus.cur_dir); end
    wait_step(n);
    checks++; if (n != TD) begin errs++; $display("FAIL first_step_latency got=%0d exp=%0d", n, TD); end
    checks++; if (bus.step_dir !== 3'd3) begin errs++; $display("FAIL first_step_dir got=%0d exp=3", bus.step_dir); end
    wait_step(n);
    checks++; if (n != TD) begin errs++; $display("FAIL step_period got=%0d exp=%0d", n, TD); end
  endtask

  task automatic test_filter();
    automatic int n;
    key(3'b001);
    checks++; if (bus.q_count !== 3'd0) begin errs++; $display("FAIL reverse_drop got=%0d exp=0", bus.q_count); end
    key(3'b010);
    checks++; if (bus.q_count !== 3'd1) begin errs++; $display("FAIL push_left got=%0d exp=1", bus.q_count); end
    key(3'b000);
    checks++; if (bus.q_count !== 3'd1) begin errs++; $display("FAIL reverse_of_tail got=%0d exp=1", bus.q_count); end
    wait_step(n);
    checks++; if (bus.step_dir !== 3'd2) begin errs++; $display("FAIL pop_step_dir got=%0d exp=2", bus.step_dir); end
    checks++; if (bus.q_count !== 3'd0) begin errs++; $display("FAIL pop_q_count got=%0d exp=0", bus.q_count); end
    key(3'b011);
    wait_step(n);
    checks++; if (bus.cur_dir !== 3'd3) begin errs++; $display("FAIL back_to_up got=%0d exp=3", bus.cur_dir); end
  endtask

  task automatic test_overflow();
    automatic int n;
    key(3'd2); key(3'd3); key(3'd2); key(3'd3);
    checks++; if (bus.q_count !== 3'd4) begin errs++; $display("FAIL fill_q_count got=%0d exp=4", bus.q_count); end
    checks++; if (bus.q_overflow !== 1'b0) begin errs++; $display("FAIL fill_no_ovf got=%b exp=0", bus.q_overflow); end
    key(3'd0);
    checks++; if (bus.q_overflow !== 1'b1) begin errs++; $display("FAIL overflow_set got=%b exp=1", bus.q_overflow); end
    checks++; if (bus.q_count !== 3'd4) begin errs++; $display("FAIL overflow_count got=%0d exp=4", bus.q_count); end
    wait_step(n);
    checks++; if (bus.step_dir !== 3'd2 || bus.q_count !== 3'd3) begin errs++; $display("FAIL ovf_step1 got=dir%0d/cnt%0d exp=dir2/cnt3", bus.step_dir, bus.q_count); end
    wait_step(n);
    checks++; if (bus.step_dir !== 3'd3 || bus.q_count !== 3'd2) begin errs++; $display("FAIL ovf_step2 got=dir%0d/cnt%0d exp=dir3/cnt2", bus.step_dir, bus.q_count); end
    checks++; if (bus.q_overflow !== 1'b1) begin errs++; $display("FAIL overflow_sticky got=%b exp=1", bus.q_overflow); end
  endtask

  task automatic test_full_tick();
    key(3'd2); key(3'd3);
    checks++; if (bus.q_count !== 3'd4) begin errs++; $display("FAIL refill got=%0d exp=4", bus.q_count); end
    repeat (TD - 3) @(negedge clk);
    key(3'd0);
    checks++; if (bus.step !== 1'b1) begin errs++; $display("FAIL full_tick_step got=%b exp=1", bus.step); end
    checks++; if (bus.q_count !== 3'd4) begin errs++; $display("FAIL full_tick_count got=%0d exp=4", bus.q_count); end
    checks++; if (bus.cur_dir !== 3'd2) begin errs++; $display("FAIL full_tick_cur got=%0d exp=2", bus.cur_dir); end
  endtask

  task automatic test_restart();
    automatic int n;
    automatic bit bad = 0;
    wait_step(n); wait_step(n);
    checks++; if (bus.q_count !== 3'd2) begin errs++; $display("FAIL pre_restart_count got=%0d exp=2", bus.q_count); end
    key(3'b100);
    checks++; if (bus.restart !== 1'b1) begin errs++; $display("FAIL restart_pulse got=%b exp=1", bus.restart); end
    checks++; if (bus.q_count !== 3'd0 || bus.q_overflow !== 1'b0) begin errs++; $display("FAIL restart_flush got=cnt%0d/ovf%b exp=cnt0/ovf0", bus.q_count, bus.q_overflow); end
    checks++; if (bus.cur_dir !== 3'd4 || bus.step_dir !== 3'd4) begin errs++; $display("FAIL restart_dir got=%0d/%0d exp=4/4", bus.cur_dir, bus.step_dir); end
    checks++; if (bus.running !== 1'b0) begin errs++; $display("FAIL restart_running got=%b exp=0", bus.running); end
    @(negedge clk);
    checks++; if (bus.restart !== 1'b0) begin errs++; $display("FAIL restart_one_cycle got=%b exp=0", bus.restart); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.step !== 1'b0 || bus.running !== 1'b0) bad = 1;
    end
    checks++; if (bad) begin errs++; $display("FAIL restart_idle got=activity exp=none"); end
  endtask

  task automatic test_random();
    automatic int r;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      checks++; if (bus.step !== m_step) begin errs++; $display("FAIL rnd_step cyc=%0d got=%b exp=%b", i, bus.step, m_step); end
      checks++; if (int'(bus.step_dir) != m_sdir) begin errs++; $display("FAIL rnd_step_dir cyc=%0d got=%0d exp=%0d", i, bus.step_dir, m_sdir); end
      checks++; if (int'(bus.cur_dir) != m_cur) begin errs++; $display("FAIL rnd_cur_dir cyc=%0d got=%0d exp=%0d", i, bus.cur_dir, m_cur); end
      checks++; if (bus.running !== (m_mode == M_RUN)) begin errs++; $display("FAIL rnd_running cyc=%0d got=%b exp=%b", i, bus.running, m_mode == M_RUN); end
      checks++; if (bus.restart !== m_restart) begin errs++; $display("FAIL rnd_restart cyc=%0d got=%b exp=%b", i, bus.restart, m_restart); end
      checks++; if (int'(bus.q_count) != q.size()) begin errs++; $display("FAIL rnd_q_count cyc=%0d got=%0d exp=%0d", i, bus.q_count, q.size()); end
      checks++; if (bus.q_overflow !== m_ovf) begin errs++; $display("FAIL rnd_q_overflow cyc=%0d got=%b exp=%b", i, bus.q_overflow, m_ovf); end
      rst = ($urandom_range(0, 699) == 0);
      bus.key_valid = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 95);
      if (r == 0) bus.key_dir = 3'b100;
      else begin
        r = r % 8;
        bus.key_dir = (r == 4) ? 3'b101 : 3'(r);
      end
    end
    bus.key_valid = 1'b0; rst = 1'b0;
  endtask

  initial begin
    bus.key_valid = 1'b0; bus.key_dir = 3'b000;
    test_reset();
    test_start();
    test_filter();
    test_overflow();
    test_full_tick();
    test_restart();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/snake_move_scheduler.md
Name: snake_move_scheduler

Overview:
- Sits between the PS/2 keyboard direction decoder and the snake game engine.
- Buffers decoded direction keypresses in a small FIFO and rejects reversals and duplicates.
- Generates the game-step tick and releases exactly one committed direction per step.
- Handles restart: flushes all state and waits for the first direction key before running.

Parameters:
- TICK_DIV, 5000000: clk cycles per game step (10 steps/s at 50 MHz); must be >= 4.
- QDEPTH, 4: direction queue depth, power of 2, >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle pulse per decoded keypress.
- key_dir  in  3  key code: 3'b011 up(w), 3'b010 left(a), 3'b001 down(s), 3'b000 right(d), 3'b100 restart; 3'b101-3'b111 are ignored.
- step  out  1  one-cycle pulse; the game engine advances one cell.
- step_dir  out  3  direction valid with step; holds its value between steps.
- cur_dir  out  3  committed direction.
- running  out  1  high in RUN.
- restart  out  1  one-cycle pulse on a restart key.
- q_count  out  $clog2(QDEPTH)+1  queue occupancy.
- q_overflow  out  1  sticky; a key was dropped because the queue was full.

Behaviour:
- Reset values:
  - state IDLE.
  - step=0, running=0, restart=0, q_count=0, q_overflow=0.
  - cur_dir=step_dir=3'b100.
  - Tick counter 0; queue pointers 0.
- Opposite rule: directions x and y (both < 4) are opposite iff (x ^ y) == 3'b010. Pairs are w/s and a/d.
- Effective tail (E): the last queued entry, or cur_dir if the queue is empty. E is evaluated before any same-cycle pop.
- State machine:
  - IDLE:
    - Counter held at 0; no step pulses.
    - key_valid with a direction: cur_dir <= key_dir and go to RUN next cycle. The queue stays empty.
  - RUN:
    - Counter increments every cycle. At TICK_DIV-1 it wraps to 0 and asserts tick.
    - On tick:
      - If the queue is non-empty, pop the head into cur_dir.
      - Pulse step in the same cycle as the tick register update; step_dir = cur_dir after the pop.
      - Step latency from tick: one registered cycle.
      - The first step comes TICK_DIV cycles after entering RUN, then every TICK_DIV cycles.
    - key_valid with a direction:
      - Push if key_dir != E and key_dir is not opposite to E.
      - Otherwise discard silently with no flag.
    - Queue full and no pop in the same cycle: drop the key and set q_overflow.
    - Queue full with a same-cycle pop: accept the push; q_count stays QDEPTH.
    - Simultaneous push and pop: the pop takes the old head and the push writes the tail. q_count is unchanged.
  - RESTART (single cycle, entered from any state on key_valid && key_dir==3'b100):
    - restart=1.
    - Flush the queue; clear q_overflow and the counter.
    - cur_dir=step_dir=3'b100; running=0.
    - Next state IDLE.
  - Restart has priority over a tick in the same cycle; no step is pulsed.
- key_dir 5-7: ignored in all states.
- rst asserted mid-run: all state returns to the reset values on the next edge and any queued entries are lost.
- Pointers wrap modulo QDEPTH.

Optional Feature:
- Macro SPEEDUP_EN.
- When defined:
  - The step period starts at TICK_DIV.
  - After every 16 steps, the period decreases by TICK_DIV>>4.
  - Floor is TICK_DIV>>2.
  - A period change applies starting with the next counter wrap.
  - Restart and rst restore the period to TICK_DIV.
- When undefined: the period is fixed at TICK_DIV and no period register exists.

Test Plan:
1. TICK_DIV=8, QDEPTH=4. rst, then 100 idle cycles -> step never pulses, running=0, cur_dir=3'b100, q_count=0.
2. In IDLE, pulse key_dir=3'b011 -> running=1 next cycle, cur_dir=3; step pulses 8 cycles later with step_dir=3, then every 8 cycles.
3. In RUN with cur_dir=3:
   - Key 3'b001 -> dropped, q_count=0.
   - Key 3'b010 -> q_count=1.
   - Key 3'b000 -> dropped (opposite of tail a).
   - At the next step -> step_dir=2, q_count=0.
4. In RUN with cur_dir=3, push 2,3,2,3 -> q_count=4. Then push 0 -> dropped, q_overflow=1. q_overflow stays 1 across the following steps.
5. Queue full, key 0 arriving in the same cycle as the tick -> accepted, q_count=4, head popped into cur_dir=2.
6. In RUN with 2 entries queued, key 3'b100 -> restart pulse for one cycle, q_count=0, q_overflow=0, cur_dir=4, running=0; no step until a new direction key.
